// File: rtl/pattern_animator_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pattern_animator_pkg : shared types and helpers for pattern_animator |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pattern_animator_pkg;

    typedef enum logic [1:0] {
        MODE_DEFAULT = 2'd0,
        MODE_WIPE    = 2'd1,
        MODE_HYPER   = 2'd2,
        MODE_DIAG    = 2'd3
    } mode_e;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    function automatic mode_e note_to_mode(input logic [3:0] note);
        case (note % 4'd3)
            4'd0:    return MODE_WIPE;
            4'd1:    return MODE_HYPER;
            default: return MODE_DIAG;
        endcase
    endfunction

    // Width that holds any product of an X delta and a Y delta.
    function automatic int calc_w_xy(input int wx, input int wy);
        return 2 * ((wx > wy) ? wx : wy);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pattern_animator_tick_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tick_prescaler : free-running counter, tick while count is all-ones  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tick_prescaler #(
    parameter int W_TICK = 20
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    logic [W_TICK-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign tick = &r_count;

endmodule
`default_nettype wire

// File: rtl/pattern_animator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pattern_animator : cursors, note-driven mode FSM and registered RGB  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pattern_animator
    import pattern_animator_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int W_RED         = 4,
    parameter int W_GREEN       = 4,
    parameter int W_BLUE        = 4,
    parameter int W_TICK        = 20,
    parameter int HOLD_TICKS    = 64,
    parameter int W_X           = $clog2(SCREEN_WIDTH),
    parameter int W_Y           = $clog2(SCREEN_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_X-1:0]     x,
    input  logic [W_Y-1:0]     y,
    input  logic               up,
    input  logic               down,
    input  logic               note_vld,
    input  logic [3:0]         note_idx,
    output logic [W_RED-1:0]   red,
    output logic [W_GREEN-1:0] green,
    output logic [W_BLUE-1:0]  blue,
    output logic [1:0]         mode,
    output logic               tick
);

    localparam int               c_W_XY      = calc_w_xy(W_X, W_Y);
    localparam int               c_W_HOLD    = $clog2(HOLD_TICKS + 1);
    localparam logic [W_X-1:0]   c_X_LAST    = W_X'(SCREEN_WIDTH - 1);
    localparam logic [W_Y-1:0]   c_Y_LAST    = W_Y'(SCREEN_HEIGHT - 1);
    localparam logic [W_Y-1:0]   c_Y_MID     = W_Y'(SCREEN_HEIGHT / 2);
    localparam logic [c_W_XY-1:0] c_HYPER_LIM = c_W_XY'((SCREEN_WIDTH * SCREEN_HEIGHT) / 16);
    localparam logic [c_W_HOLD-1:0] c_HOLD_LOAD = c_W_HOLD'(HOLD_TICKS);

    logic [W_X-1:0]      r_cursor_x;
    logic [W_Y-1:0]      r_cursor_y;
    state_e              r_state, w_state_nxt;
    mode_e               r_mode, w_mode_nxt;
    logic [c_W_HOLD-1:0] r_hold, w_hold_nxt;
    logic                w_note_ok;

    tick_prescaler #(.W_TICK(W_TICK)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cursor_x <= '0;
            r_cursor_y <= c_Y_MID;
        end else if (tick) begin
            r_cursor_x <= (r_cursor_x == c_X_LAST) ? '0 : r_cursor_x + 1'b1;
            if (up && !down && r_cursor_y != c_Y_LAST) begin
                r_cursor_y <= r_cursor_y + 1'b1;
            end else if (down && !up && r_cursor_y != '0) begin
                r_cursor_y <= r_cursor_y - 1'b1;
            end
        end
    end

    assign w_note_ok = note_vld && (note_idx <= 4'd11);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_DEFAULT;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_hold  <= w_hold_nxt;
        end
    end

    // A valid note always wins over the hold countdown, including its last tick.
    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_hold_nxt  = r_hold;
        if (w_note_ok) begin
            w_state_nxt = ST_ACTIVE;
            w_mode_nxt  = note_to_mode(note_idx);
            w_hold_nxt  = c_HOLD_LOAD;
        end else if (r_state == ST_ACTIVE && tick) begin
            if (r_hold == c_W_HOLD'(1)) begin
                w_state_nxt = ST_IDLE;
                w_mode_nxt  = MODE_DEFAULT;
                w_hold_nxt  = '0;
            end else begin
                w_hold_nxt  = r_hold - 1'b1;
            end
        end
    end

    assign mode = r_mode;

    logic [c_W_XY-1:0]  w_x_ext, w_y_ext, w_sum, w_diff, w_cur_sum;
    logic [W_X-1:0]     w_dx_raw;
    logic [W_Y-1:0]     w_dy_raw;
    logic [c_W_XY-1:0]  w_dx, w_dy, w_prod;
    logic [W_RED-1:0]   w_red;
    logic [W_GREEN-1:0] w_green;
    logic [W_BLUE-1:0]  w_blue;

    always_comb begin
        w_x_ext   = c_W_XY'(x);
        w_y_ext   = c_W_XY'(y);
        w_sum     = w_x_ext + w_y_ext;
        w_diff    = w_x_ext - w_y_ext;
        w_cur_sum = c_W_XY'(r_cursor_x) + c_W_XY'(r_cursor_y);
        w_dx_raw  = x - r_cursor_x;
        w_dy_raw  = y - r_cursor_y;
        w_dx      = c_W_XY'(w_dx_raw);
        w_dy      = c_W_XY'(w_dy_raw);
        w_prod    = w_dx * w_dy;
        w_red     = '0;
        w_green   = '0;
        w_blue    = '0;
        case (r_mode)
            MODE_DEFAULT: begin
                if (x < r_cursor_x) w_red  = '1;
                else                w_blue = '1;
                if (y < r_cursor_y) w_green = '1;
            end
            MODE_WIPE: begin
                if (x < r_cursor_x) begin
                    w_red   = W_RED'(w_sum >> 3);
                    w_green = W_GREEN'(w_diff >> 3);
                    w_blue  = W_BLUE'(x >> 3);
                end
            end
            MODE_HYPER: begin
                if (w_prod < c_HYPER_LIM) begin
                    w_red   = W_RED'(x >> 3);
                    w_green = W_GREEN'(y >> 3);
                    w_blue  = '1;
                end
            end
            default: begin
                if (w_sum < w_cur_sum) begin
                    w_red   = '1;
                    w_green = '1;
                    w_blue  = W_BLUE'(w_sum >> 3);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red   <= '0;
            green <= '0;
            blue  <= '0;
        end else begin
            red   <= w_red;
            green <= w_green;
            blue  <= w_blue;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_animator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pattern_animator : random stimulus against a behavioural model    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pattern_animator;

    localparam int SW = 16;
    localparam int SH = 8;
    localparam int WT = 2;
    localparam int HT = 3;
    localparam int WR = 4;
    localparam int WG = 4;
    localparam int WB = 4;
    localparam int WX = $clog2(SW);
    localparam int WY = $clog2(SH);
    localparam int WXY = 2 * ((WX > WY) ? WX : WY);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [WX-1:0] x = '0;
    logic [WY-1:0] y = '0;
    logic          up = 1'b0;
    logic          down = 1'b0;
    logic          note_vld = 1'b0;
    logic [3:0]    note_idx = '0;
    logic [WR-1:0] red;
    logic [WG-1:0] green;
    logic [WB-1:0] blue;
    logic [1:0]    mode;
    logic          tick;

    pattern_animator #(
        .SCREEN_WIDTH (SW), .SCREEN_HEIGHT(SH),
        .W_RED(WR), .W_GREEN(WG), .W_BLUE(WB),
        .W_TICK(WT), .HOLD_TICKS(HT)
    ) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .up(up), .down(down),
        .note_vld(note_vld), .note_idx(note_idx),
        .red(red), .green(green), .blue(blue), .mode(mode), .tick(tick)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Model state: edges since reset release, cursors, pattern and hold.
    int m_cycles, m_cx, m_cy, m_mode, m_hold;
    int e_r, e_g, e_b;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cycles = 0; m_cx = 0; m_cy = SH / 2; m_mode = 0; m_hold = 0;
        e_r = 0; e_g = 0; e_b = 0;
    endtask

    task automatic pixel(input int px, input int py, input int cx, input int cy, input int md,
                         output int r, output int g, output int b);
        int mr, mg, mb, dx, dy;
        mr = (1 << WR) - 1; mg = (1 << WG) - 1; mb = (1 << WB) - 1;
        r = 0; g = 0; b = 0;
        if (md == 0) begin
            r = (px < cx) ? mr : 0;
            b = (px < cx) ? 0 : mb;
            g = (py < cy) ? mg : 0;
        end else if (md == 1) begin
            if (px < cx) begin
                r = (((px + py) % (1 << WXY)) >> 3) & mr;
                g = (((px - py + (1 << WXY)) % (1 << WXY)) >> 3) & mg;
                b = (px >> 3) & mb;
            end
        end else if (md == 2) begin
            dx = (px - cx + (1 << WX)) % (1 << WX);
            dy = (py - cy + (1 << WY)) % (1 << WY);
            if (dx * dy < (SW * SH) / 16) begin
                r = (px >> 3) & mr; g = (py >> 3) & mg; b = mb;
            end
        end else begin
            if (px + py < cx + cy) begin
                r = mr; g = mg; b = ((px + py) >> 3) & mb;
            end
        end
    endtask

    // One clock: check outputs, drive new inputs, advance the model, wait.
    task automatic step_cycle();
        bit t;
        check("tick", 32'(tick), 32'(m_cycles % (1 << WT) == (1 << WT) - 1));
        check("mode", 32'(mode), 32'(m_mode));
        check("red", 32'(red), 32'(e_r));
        check("green", 32'(green), 32'(e_g));
        check("blue", 32'(blue), 32'(e_b));
        t = (m_cycles % (1 << WT) == (1 << WT) - 1);
        x = WX'($urandom_range(0, SW - 1));
        y = WY'($urandom_range(0, SH - 1));
        if (t && m_mode != 0 && m_hold == 1 && $urandom_range(0, 1) == 1) begin
            note_vld = 1'b1;
            note_idx = 4'($urandom_range(0, 11));
        end else begin
            note_vld = ($urandom_range(0, 7) == 0);
            note_idx = 4'($urandom_range(0, 15));
        end
        pixel(int'(x), int'(y), m_cx, m_cy, m_mode, e_r, e_g, e_b);
        if (t) begin
            m_cx = (m_cx + 1) % SW;
            if (up && !down)      m_cy = (m_cy < SH - 1) ? m_cy + 1 : m_cy;
            else if (down && !up) m_cy = (m_cy > 0) ? m_cy - 1 : m_cy;
        end
        if (note_vld && note_idx <= 11) begin
            m_mode = int'(note_idx) % 3 + 1;
            m_hold = HT;
        end else if (m_mode != 0 && t) begin
            m_hold--;
            if (m_hold == 0) m_mode = 0;
        end
        m_cycles++;
        @(negedge clk);
    endtask

    task automatic run_phases(input int n);
        for (int p = 0; p < n; p++) begin
            case ($urandom_range(0, 3))
                0: begin up = 1'b1; down = 1'b0; end
                1: begin up = 1'b0; down = 1'b1; end
                2: begin up = 1'b1; down = 1'b1; end
                default: begin up = 1'b0; down = 1'b0; end
            endcase
            repeat (48) step_cycle();
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_mode", 32'(mode), 32'd0);
        check("reset_rgb", {20'd0, red, green, blue}, 32'd0);
        rst = 1'b0;
        model_reset();
        run_phases(16);

        // Get into an active pattern, then hit reset between clock edges.
        for (int i = 0; i < 200; i++) begin
            if (m_mode != 0) break;
            step_cycle();
        end
        check("active_before_async", 32'(m_mode != 0), 32'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_mode", 32'(mode), 32'd0);
        check("async_tick", 32'(tick), 32'd0);
        check("async_rgb", {20'd0, red, green, blue}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        up = 1'b0; down = 1'b0;
        run_phases(16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pattern_animator.md
Name: pattern_animator

Overview:
- Parametrised successor to the top-level animated-pattern logic: a free-running tick prescaler, a wrapping X cursor and a clamped up/down Y cursor.
- A note-driven mode FSM with hold timeout picks one of four pixel patterns.
- Generates registered RGB for the current (x, y) scan position.
- Sits between the note recognizer and the VGA/LCD output path.

Parameters:
- screen_width, 640, horizontal resolution; cursor X wrap point
- screen_height, 480, vertical resolution; cursor Y clamp range
- w_red, 4, red channel width
- w_green, 4, green channel width
- w_blue, 4, blue channel width
- w_tick, 20, prescaler width; one tick every 2**w_tick clocks
- hold_ticks, 64, ticks a recognised note keeps its pattern active (>= 1)
- w_x, $clog2(screen_width), X coordinate width (derived)
- w_y, $clog2(screen_height), Y coordinate width (derived)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- x  in  w_x  current pixel column
- y  in  w_y  current pixel row
- up  in  1  move cursor Y +1 per tick
- down  in  1  move cursor Y -1 per tick
- note_vld  in  1  single-cycle note strobe
- note_idx  in  4  note index, 0..11 valid
- red  out  w_red  pixel red, registered
- green  out  w_green  pixel green, registered
- blue  out  w_blue  pixel blue, registered
- mode  out  2  current pattern: 0 default, 1 wipe, 2 hyperbola, 3 diagonal
- tick  out  1  prescaler pulse

Behaviour:
- Reset (async assert, sync release):
  - prescaler = 0, cursor_x = 0, cursor_y = screen_height/2, hold = 0.
  - FSM = IDLE, mode = 0, red/green/blue = 0, tick = 0.
- Prescaler:
  - w_tick-bit counter increments every clk.
  - tick = 1 while count == all-ones, so the first tick is at clock 2**w_tick - 1 after reset release; then every 2**w_tick clocks.
- cursor_x: on tick, 0..screen_width-1, wraps to 0 after screen_width-1.
- cursor_y, on tick only:
  - up & !down: +1, saturating at screen_height-1.
  - down & !up: -1, saturating at 0.
  - Both or neither: hold.
- Mode FSM:
  - IDLE (mode 0):
    - note_vld with note_idx <= 11 -> ACTIVE.
    - mode = (note_idx mod 3) + 1; hold = hold_ticks.
    - note_idx 12..15 is ignored.
  - ACTIVE:
    - A valid note reloads hold and mode (retrigger).
    - Otherwise, on tick, hold decrements. When hold goes 1 -> 0, the next state is IDLE and mode = 0.
    - Simultaneous valid note_vld and tick with hold == 1: the note wins (reload, stay ACTIVE).
  - mode is a registered output; it changes the cycle after note_vld.
- Pixel datapath: one-cycle latency; RGB at cycle n+1 is a function of x, y, cursors and mode at cycle n.
  - mode 0: red = all-ones if x < cursor_x, else blue = all-ones; green = all-ones if y < cursor_y; other channels 0.
  - mode 1: if x < cursor_x, red = (x+y)>>3, green = (x-y)>>3, blue = x>>3, each truncated to channel width; else all 0.
  - mode 2:
    - dx = (x - cursor_x) mod 2**w_x and dy = (y - cursor_y) mod 2**w_y, zero-extended to w_xy = 2*max(w_x, w_y).
    - If dx*dy < (screen_width*screen_height)/16: red = x>>3, green = y>>3, blue = all-ones; else 0.
  - mode 3: if x+y < cursor_x+cursor_y (computed at w_xy width): red = green = all-ones, blue = (x+y)>>3; else 0.
- Reset mid-operation: all state returns to reset values immediately, including an ACTIVE mode and pending hold.

Decomposition:
- Package pattern_animator_pkg:
  - Mode enum (MODE_DEFAULT, MODE_WIPE, MODE_HYPER, MODE_DIAG).
  - FSM state enum (ST_IDLE, ST_ACTIVE).
  - Function note_to_mode (note mod 3 + 1 lookup).
  - w_xy helper function.
- One sub-module: tick_prescaler (parameter w_tick; ports clk, rst, tick).

Test Plan (screen_width 16, screen_height 8, w_tick 2, hold_ticks 3):
- Reset release, idle inputs -> tick high at clocks 3, 7, 11; cursor_x 1, 2, 3 after each; mode 0; RGB 0 before first active clock.
- Hold up for 8 ticks from cursor_y 4 -> cursor_y 5, 6, 7, 7, 7 (saturates). Hold down 10 ticks -> reaches 0 and stays. up & down together -> unchanged.
- Mode changes:
  - note_vld with note_idx = 4 -> mode = 2 next cycle.
  - After 3 ticks without notes -> mode = 0 on the cycle after the third tick.
  - note_idx = 13 -> mode stays 0.
- Retrigger: ACTIVE with hold == 1, note_vld(idx 9) coincident with tick -> stays ACTIVE, mode 1, hold = 3.
- Pixel check:
  - mode 0, cursor_x = 5, cursor_y = 4, x = 3, y = 6 -> next cycle red = F, green = 0, blue = 0.
  - mode 3, same cursors, x = 2, y = 2 -> red = F, green = F, blue = 0.
- Async reset asserted mid-clock while ACTIVE -> all outputs 0 and mode 0 immediately without a clock edge; cursor_y = 4 after release.
